// File: rtl/rs232_rx.sv
// RS-232 receiver: 8N1 by default; define RS232_RX_PARITY_EN for 8E1 with even-parity checking.
// Delivered bytes are held in data with a valid/ack handshake; errors are one-cycle pulses.
module rs232_rx #(
    parameter int FREQ = 50_000_000,
    parameter int BAUD = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ack,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);
    localparam int BIT_CLKS  = FREQ / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;
    localparam int CW        = $clog2(BIT_CLKS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef RS232_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t        state;
    logic          rx_meta;
    logic          rxs;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          bit_tick;

    // Two-flop synchronizer; resets to the idle-high line level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    assign bit_tick = (clk_cnt == CW'(BIT_CLKS - 1));
    assign busy     = (state != IDLE);

`ifdef RS232_RX_PARITY_EN
    logic par_ok;
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            par_ok     <= 1'b1;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef RS232_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (valid && ack)
                valid <= 1'b0;

            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rxs)
                        state <= START;
                end
                // Re-check the start bit at mid-bit so every later sample lands mid-bit.
                START: begin
                    if (clk_cnt == CW'(HALF_CLKS - 1)) begin
                        clk_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        shift   <= {rxs, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) begin
`ifdef RS232_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`ifdef RS232_RX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        par_ok  <= ~(^{shift, rxs});
                        state   <= STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
`endif
                // A later valid assignment overrides the ack clear above, so an ack
                // coinciding with delivery keeps the new byte valid.
                STOP: begin
                    if (bit_tick) begin
                        clk_cnt <= '0;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
`ifdef RS232_RX_PARITY_EN
                        end else if (!par_ok) begin
                            parity_err <= 1'b1;
                            state      <= IDLE;
`endif
                        end else begin
                            data  <= shift;
                            valid <= 1'b1;
                            if (valid && !ack)
                                overrun <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                BREAK: begin
                    clk_cnt <= '0;
                    if (rxs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
